// File: rtl/instruction_fetch.sv
// Fetch stage: PC register plus word-organised instruction memory with a loader write port; IF_MEM_CLEAR_EN adds memory clear on reset.
// Latency: zero-cycle combinational read of mem[pc]; PC advances by 4 on each rising edge.
// Backpressure: i_halt or i_stall holds the PC; loader writes proceed regardless of either.
module instruction_fetch #(
    parameter int MEM_DEPTH_WORDS = 256
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_halt,
    input  logic        i_write_instruction,
    input  logic [31:0] i_instruction,
    input  logic [31:0] i_address,
    output logic [31:0] o_instruction,
    output logic [31:0] o_pc
);

    localparam int AW = $clog2(MEM_DEPTH_WORDS);

    logic [31:0]   pc;
    logic [31:0]   mem [MEM_DEPTH_WORDS];
    logic [AW-1:0] wr_index;
    logic [AW-1:0] rd_index;
    logic          unused_addr_bits;

    // Byte-offset and out-of-range address bits are dropped so addresses alias modulo the memory size.
    assign wr_index         = i_address[AW+1:2];
    assign rd_index         = pc[AW+1:2];
    assign unused_addr_bits = ^{i_address[31:AW+2], i_address[1:0]};

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            pc <= '0;
        end else if (!i_halt && !i_stall) begin
            pc <= pc + 32'd4;
        end
    end

`ifdef IF_MEM_CLEAR_EN
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < MEM_DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (i_write_instruction) begin
            mem[wr_index] <= i_instruction;
        end
    end
`else
    // No reset on the array so it can map to block RAM; reset only gates the write enable.
    always_ff @(posedge i_clk) begin
        if (i_reset && i_write_instruction) begin
            mem[wr_index] <= i_instruction;
        end
    end
`endif

    assign o_instruction = mem[rd_index];
    assign o_pc          = pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench driving a 256-word and a 4-word instance with shared stimulus.
module tb_instruction_fetch;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        halt;
    logic        we;
    logic [31:0] wdat;
    logic [31:0] addr;
    logic [31:0] instr_a, pc_a;
    logic [31:0] instr_b, pc_b;

    int checks   = 0;
    int failures = 0;

`ifdef IF_MEM_CLEAR_EN
    localparam logic [31:0] W0_AFTER_RST = 32'h0;
    localparam logic [31:0] W1_AFTER_RST = 32'h0;
`else
    localparam logic [31:0] W0_AFTER_RST = 32'h1010_1010;
    localparam logic [31:0] W1_AFTER_RST = 32'h0BAD_F00D;
`endif

    instruction_fetch #(.MEM_DEPTH_WORDS(256)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_stall(stall), .i_halt(halt),
        .i_write_instruction(we), .i_instruction(wdat), .i_address(addr),
        .o_instruction(instr_a), .o_pc(pc_a)
    );

    instruction_fetch #(.MEM_DEPTH_WORDS(4)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_stall(stall), .i_halt(halt),
        .i_write_instruction(we), .i_instruction(wdat), .i_address(addr),
        .o_instruction(instr_b), .o_pc(pc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic both(input string tag, input logic [31:0] epc, input logic [31:0] einstr);
        check({tag, "_pc_a"}, pc_a, epc);
        check({tag, "_ins_a"}, instr_a, einstr);
        check({tag, "_pc_b"}, pc_b, epc);
        check({tag, "_ins_b"}, instr_b, einstr);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; halt = 1'b1; we = 1'b0; wdat = '0; addr = '0;

        // Asynchronous reset before any clock edge
        #3 rst = 1'b0;
        #1;
        check("rst_async_pc_a", pc_a, 32'h0);
        check("rst_async_pc_b", pc_b, 32'h0);
`ifdef IF_MEM_CLEAR_EN
        check("rst_async_ins_a", instr_a, 32'h0);
        check("rst_async_ins_b", instr_b, 32'h0);
`endif
        tick();
        check("rst_hold_pc_a", pc_a, 32'h0);
        rst = 1'b1;

        // Load under halt
        we = 1'b1; addr = 32'h0; wdat = 32'h1010_1010;
        tick();
        both("load0", 32'h0, 32'h1010_1010);
        addr = 32'h4; wdat = 32'h1234_5678;
        tick();
        addr = 32'h8; wdat = 32'hABCD_EF01;
        tick();
        addr = 32'hC; wdat = 32'hFEDC_BA98;
        tick();
        both("load3", 32'h0, 32'h1010_1010);
        we = 1'b0;
        tick();
        both("halted", 32'h0, 32'h1010_1010);

        // Run
        halt = 1'b0;
        tick();
        both("run4", 32'h4, 32'h1234_5678);

        // Stall two cycles at pc=4
        stall = 1'b1;
        tick();
        both("stall1", 32'h4, 32'h1234_5678);
        tick();
        both("stall2", 32'h4, 32'h1234_5678);
        stall = 1'b0;
        tick();
        both("run8", 32'h8, 32'hABCD_EF01);

        // Write the word the PC reaches on this same edge
        we = 1'b1; addr = 32'hC; wdat = 32'hDEAD_BEEF;
        tick();
        both("wr_next", 32'hC, 32'hDEAD_BEEF);

        // Unaligned address 0x6 targets word 1
        addr = 32'h6; wdat = 32'h0BAD_F00D;
        tick();
        we = 1'b0;
        check("wrap_pc_a", pc_a, 32'h10);
        check("wrap_pc_b", pc_b, 32'h10);
        check("wrap_ins_b", instr_b, 32'h1010_1010);
        tick();
        check("wrap1_pc_b", pc_b, 32'h14);
        check("wrap1_ins_b", instr_b, 32'h0BAD_F00D);

        // Halt takes priority, stall alone also holds
        halt = 1'b1; stall = 1'b1;
        tick();
        check("halt_stall_pc_a", pc_a, 32'h14);
        halt = 1'b0;
        tick();
        check("stall_only_pc_b", pc_b, 32'h14);
        stall = 1'b0;
        tick();
        check("resume_pc_a", pc_a, 32'h18);
        check("resume_pc_b", pc_b, 32'h18);

        // Mid-cycle reset with a write attempted while reset is asserted
        #2 rst = 1'b0; we = 1'b1; addr = 32'h0; wdat = 32'h9999_9999;
        #1;
        check("rst_mid_pc_a", pc_a, 32'h0);
        check("rst_mid_pc_b", pc_b, 32'h0);
        tick();
        both("rst_nowrite", 32'h0, W0_AFTER_RST);
        rst = 1'b1; we = 1'b0;
        tick();
        both("post_rst4", 32'h4, W1_AFTER_RST);
        tick();
        check("post_rst8_pc_a", pc_a, 32'h8);
        check("post_rst8_pc_b", pc_b, 32'h8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the pipelined MIPS-style processor. Holds the program counter (PC) and a word-organised instruction memory that the debug/loader path fills through a write port. Each cycle it presents the instruction at the current PC to the IF/ID boundary. It advances the PC by 4 unless the pipeline stalls or the processor is halted.

## Interface
Parameters:
- `MEM_DEPTH_WORDS`, default 256: instruction memory depth in 32-bit words; must be a power of two.

Ports:
- `i_clk`  in  1  system clock; all state changes on its rising edge.
- `i_reset`  in  1  reset, asynchronous, active-low. Name kept per codebase convention; asserted when 0.
- `i_stall`  in  1  hazard stall; holds the PC.
- `i_halt`  in  1  processor halt; holds the PC.
- `i_write_instruction`  in  1  write enable for the instruction memory.
- `i_instruction`  in  32  word to write.
- `i_address`  in  32  byte address of the word to write.
- `o_instruction`  out  32  instruction at the current PC.
- `o_pc`  out  32  current PC (byte address).

## Operation
- PC register, 32 bits. Instruction memory is an array of `MEM_DEPTH_WORDS` words.
- Word index is computed as `addr[log2(MEM_DEPTH_WORDS)+1:2]`.
  - Bits [1:0] are ignored; no alignment check.
  - Upper bits are ignored, so addresses alias modulo memory size.
- Write: on a rising edge with `i_write_instruction`=1, `mem[index(i_address)] <= i_instruction`.
  - Writes are independent of `i_halt` and `i_stall`.
  - Loaders are expected to hold `i_halt`=1 while writing.
- Read is combinational: `o_instruction = mem[index(pc)]`, and `o_pc = pc`.
- PC update priority, evaluated on each rising edge:
  1. reset asserted: pc = 0
  2. `i_halt`=1: hold
  3. `i_stall`=1: hold
  4. otherwise: pc <= pc + 4
- PC arithmetic is 32-bit modulo 2^32. The memory index wraps naturally: after the last word, fetch returns to word 0, while the PC keeps counting.
- Same-edge write to the word currently addressed by the PC: `o_instruction` shows the new data after that edge.
- Without `IF_MEM_CLEAR_EN`, memory contents are not reset and are undefined until written. Reset does not disturb an in-progress write stream beyond dropping writes on edges where reset is asserted.

## Timing
- Reset asserted: `o_pc` = 0 immediately, with no clock required.
  - `o_instruction` = `mem[0]`, which is 0 with `IF_MEM_CLEAR_EN`, undefined otherwise.
  - While reset is asserted, no writes occur and the PC does not advance.
- Reset release: the first rising edge with reset deasserted and neither halt nor stall moves the PC to 4.
- Zero-cycle read latency: `o_instruction` corresponds to `o_pc` in the same cycle.
- Write-to-fetch latency: data written on edge N is visible at `o_instruction` from edge N onward if the PC points to that word.
- Halt/stall take effect on the edge they are sampled high. The PC resumes incrementing on the first edge where both are low.

## Configuration
- `IF_MEM_CLEAR_EN` defined: reset also clears every memory word to 32'h0, asynchronously with the PC.
- `IF_MEM_CLEAR_EN` not defined: memory has no reset, which allows block-RAM inference. All other behaviour is identical.

## Test plan
- Reset: drive `i_reset`=0 mid-cycle -> `o_pc`=0 without waiting for a clock edge. With `IF_MEM_CLEAR_EN`, `o_instruction`=0.
- Load under halt: `i_halt`=1, write 10101010@0x0, 12345678@0x4, ABCDEF01@0x8, FEDCBA98@0xC -> `o_pc` stays 0 and `o_instruction`=10101010 after the first write.
- Run: drop `i_write_instruction`, then `i_halt` -> consecutive cycles show (pc, instr) = (0,10101010), (4,12345678), (8,ABCDEF01), (C,FEDCBA98).
- Stall: assert `i_stall` for 2 cycles at pc=4 -> `o_pc` stays 4 and `o_instruction` stays 12345678; PC=8 one edge after release.
- Write while running: write 0xDEADBEEF to the address the PC reaches next cycle -> that fetch returns DEADBEEF. Unaligned `i_address` 0x6 writes word 1.
- Wrap: `MEM_DEPTH_WORDS`=4, run from 0 -> `o_pc`=0x10 fetches word 0 (10101010). Also assert reset mid-run -> `o_pc`=0 at once.
